dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU load/store port and a debug/loader port
//  (memory preload, register-file/memory dump benches). Grants one requester per cycle and stalls
//  the CPU (PC/regfile write freeze) when it loses. A starvation counter guarantees debug progress.
//  A lock mode lets the debug port hold the memory across a multi-word burst.
//  Sits between CPU, data memory and the debug port.
// PARAMETERS
//  ADDR_W     32  byte-address width of both ports and the memory
//  DATA_W     32  data word width
//  STARVE_MAX 4   consecutive denied debug cycles before debug wins; range 1..255
// PORTS
//  clk        input   1       clock, rising edge
//  reset      input   1       asynchronous, active-low reset
//  cpu_req    input   1       CPU load or store this cycle
//  cpu_we     input   1       1 = store, 0 = load
//  cpu_addr   input   ADDR_W  CPU byte address
//  cpu_wdata  input   DATA_W  CPU store data
//  cpu_rdata  output  DATA_W  load data; valid when cpu_req & !cpu_we & !cpu_stall
//  cpu_stall  output  1       CPU must hold PC and suppress its writeback this cycle
//  dbg_req    input   1       debug access request
//  dbg_we     input   1       1 = write, 0 = read
//  dbg_lock   input   1       keep ownership after this access (burst)
//  dbg_addr   input   ADDR_W  debug byte address
//  dbg_wdata  input   DATA_W  debug write data
//  dbg_gnt    output  1       debug access performed this cycle
//  dbg_rdata  output  DATA_W  read data; valid when dbg_gnt & !dbg_we
//  mem_we     output  1       memory write enable, sampled on clk rising edge
//  mem_addr   output  ADDR_W  memory address; word index = mem_addr[ADDR_W-1:2]
//  mem_wdata  output  DATA_W  memory write data
//  mem_rdata  input   DATA_W  combinational read data for mem_addr
// BEHAVIOUR
//  Memory read is combinational; a write commits on the next rising edge. Zero added latency when granted.
//  FSM states (registered): IDLE, CPU_OWN, DBG_OWN, DBG_LOCK. Reset -> IDLE, starve_cnt = 0.
//  Grant is combinational from the current state and the requests:
//   - DBG_LOCK: debug is granted if dbg_req. CPU is always stalled. Next state: DBG_LOCK while dbg_lock,
//     else IDLE. A cycle with dbg_req=0 stays locked. Only dbg_lock=0 releases the lock.
//   - Otherwise, if only one port requests, that port is granted.
//   - Otherwise, if both request: debug wins iff starve_cnt == STARVE_MAX, else CPU wins.
//  Next state outside DBG_LOCK: DBG_LOCK if debug granted & dbg_lock; DBG_OWN if debug granted;
//   CPU_OWN if CPU granted; IDLE if no requests. CPU_OWN/DBG_OWN are status only, with no priority effect.
//  starve_cnt: cleared on any dbg_gnt or when dbg_req=0. Otherwise +1 when debug is denied.
//   It saturates at STARVE_MAX.
//  cpu_stall = cpu_req & !cpu_granted. When cpu_req=0, cpu_stall=0.
//  dbg_gnt = dbg_req & debug granted.
//  mem_we/mem_addr/mem_wdata are muxed from the granted port. With no grant: mem_we=0 and all other
//   memory outputs are 0. mem_we never asserts for an ungranted port.
//  cpu_rdata and dbg_rdata are both driven from mem_rdata while their port is granted, else 0.
//  Reset values (reset low): cpu_stall=0, dbg_gnt=0, mem_we=0, all data/address outputs 0.
//   Asserting reset mid-burst drops the lock immediately. No write is issued during reset.
//  Simultaneous store-vs-store to the same address: only the granted one commits. The loser retries
//   (CPU by stall, debug by holding dbg_req).
//  Request inputs are sampled only while they are asserted. The debug port must hold addr/data stable
//   until dbg_gnt.
// STRUCTURE
//  Shared package cpu_pkg: state encodings ARB_IDLE/ARB_CPU_OWN/ARB_DBG_OWN/ARB_DBG_LOCK (2 bits),
//   ADDR_W/DATA_W defaults.
//  One sub-module: arb_starve_counter (saturating counter; clear/increment; at_max flag).
//  Top level holds the FSM, grant logic and the output muxes.
// TESTING
//  1. CPU only: store 32'h5 @16, then load @16 -> cpu_stall=0 throughout; load returns 5; dbg_gnt=0.
//  2. Debug only, while reset is held high: writes 5/6/3 @16/20/24, then reads -> dbg_gnt=1 each
//     cycle; reads return 5, 6, 3.
//  3. Both request every cycle, STARVE_MAX=4 -> CPU granted 4 cycles, then debug on the 5th
//     (cpu_stall=1 that cycle), then CPU again; pattern repeats.
//  4. Debug burst, dbg_lock=1 for 3 writes, then 0 on the 4th; CPU requests throughout ->
//     cpu_stall=1 for 4 cycles; CPU is granted on the 5th.
//  5. Reset pulled low mid-lock with dbg_req=1 -> next cycle state IDLE, mem_we=0, cpu_stall=0.
//     After release the CPU is granted first.
//  6. CPU load while a debug write is denied (cnt<max) -> memory is unchanged at the debug address.
//     The write commits exactly once after its later grant.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core package: arbiter state encodings
// and default memory-port widths.
package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_CPU_OWN  = 2'd1,
    ARB_DBG_OWN  = 2'd2,
    ARB_DBG_LOCK = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied debug
// cycles; at_max_o hands the next tie to debug.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // clear wins over increment; hold at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != MAX_C) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU load/store
// port and the debug/loader port.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic locked;
  logic both;
  logic at_max;
  logic cpu_win;
  logic dbg_win;
  logic cpu_g;
  logic dbg_g;

  assign locked = (state_q == ARB_DBG_LOCK);
  assign both   = cpu_req & dbg_req;

  // grant decision from state and requests
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    unique case (1'b1)
      locked: begin
        dbg_win = dbg_req;
      end
      !locked && both: begin
        dbg_win = at_max;
        cpu_win = !at_max;
      end
      !locked && !both: begin
        dbg_win = dbg_req;
        cpu_win = cpu_req;
      end
      default: ;
    endcase
  end

  // reset low blocks every grant and write
  assign cpu_g = cpu_win & reset;
  assign dbg_g = dbg_win & reset;

  // next-state: ownership tracking and lock
  always_comb begin
    state_d = ARB_IDLE;
    if (locked) begin
      state_d = dbg_lock ? ARB_DBG_LOCK
                         : ARB_IDLE;
    end else if (dbg_win) begin
      state_d = dbg_lock ? ARB_DBG_LOCK
                         : ARB_DBG_OWN;
    end else if (cpu_win) begin
      state_d = ARB_CPU_OWN;
    end
  end

  // state register; reset drops any lock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  arb_starve_counter #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (dbg_g | !dbg_req),
    .inc_i   (dbg_req & !dbg_g),
    .at_max_o(at_max)
  );

  assign cpu_stall = cpu_req & !cpu_g & reset;
  assign dbg_gnt   = dbg_g;

  // memory and read-data muxes from the winner
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    dbg_rdata = '0;
    if (dbg_g) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      dbg_rdata = mem_rdata;
    end else if (cpu_g) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      cpu_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word
// memory model and an expected-result queue.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        stall;
    logic        gnt;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] crd;
    logic [31:0] drd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic        dbg_lock;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  int          wr_cnt [0:63];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_lock (dbg_lock),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_gnt  (dbg_gnt),
    .dbg_rdata(dbg_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt[mem_addr[7:2]] <= wr_cnt[mem_addr[7:2]] + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t ex(
    input logic s, input logic g, input logic w,
    input logic [31:0] a, input logic [31:0] c,
    input logic [31:0] d);
    exp_t e;
    e.stall = s;
    e.gnt   = g;
    e.mwe   = w;
    e.maddr = a;
    e.crd   = c;
    e.drd   = d;
    return e;
  endfunction

  task automatic cpu(input logic r, input logic we,
                     input logic [31:0] a,
                     input logic [31:0] wd);
    cpu_req   = r;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
  endtask

  task automatic dbg(input logic r, input logic we,
                     input logic lk,
                     input logic [31:0] a,
                     input logic [31:0] wd);
    dbg_req   = r;
    dbg_we    = we;
    dbg_lock  = lk;
    dbg_addr  = a;
    dbg_wdata = wd;
  endtask

  task automatic step(input string tag,
                      input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    check({tag, ".stall"}, {31'b0, cpu_stall},
          {31'b0, x.stall});
    check({tag, ".gnt"}, {31'b0, dbg_gnt},
          {31'b0, x.gnt});
    check({tag, ".mem_we"}, {31'b0, mem_we},
          {31'b0, x.mwe});
    check({tag, ".mem_addr"}, mem_addr, x.maddr);
    check({tag, ".cpu_rdata"}, cpu_rdata, x.crd);
    check({tag, ".dbg_rdata"}, dbg_rdata, x.drd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = '0;
      wr_cnt[i] = 0;
    end
    reset = 1'b0;
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);

    // requests during reset: nothing granted
    cpu(1, 1, 16, 32'h9);
    dbg(1, 1, 0, 16, 32'h7);
    step("rst", ex(0, 0, 0, 0, 0, 0));
    check("rst.nowrite", wr_cnt[4], 0);
    reset = 1'b1;

    // CPU only
    dbg(0, 0, 0, 0, 0);
    cpu(1, 1, 16, 32'h5);
    step("t1_st", ex(0, 0, 1, 16, 0, 0));
    cpu(1, 0, 16, 0);
    step("t1_ld", ex(0, 0, 0, 16, 5, 0));

    // debug only
    cpu(0, 0, 0, 0);
    dbg(1, 1, 0, 16, 32'h5);
    step("t2_w16", ex(0, 1, 1, 16, 0, 5));
    dbg(1, 1, 0, 20, 32'h6);
    step("t2_w20", ex(0, 1, 1, 20, 0, 0));
    dbg(1, 1, 0, 24, 32'h3);
    step("t2_w24", ex(0, 1, 1, 24, 0, 0));
    dbg(1, 0, 0, 16, 0);
    step("t2_r16", ex(0, 1, 0, 16, 0, 5));
    dbg(1, 0, 0, 20, 0);
    step("t2_r20", ex(0, 1, 0, 20, 0, 6));
    dbg(1, 0, 0, 24, 0);
    step("t2_r24", ex(0, 1, 0, 24, 0, 3));

    // both every cycle: 4 CPU then 1 debug
    cpu(1, 0, 16, 0);
    dbg(1, 0, 0, 20, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        step("t3_cpu", ex(0, 0, 0, 16, 5, 0));
      end
      step("t3_dbg", ex(1, 1, 0, 20, 0, 6));
    end

    // starve debug, then locked burst
    cpu(1, 0, 16, 0);
    dbg(1, 1, 1, 32, 32'hA1);
    for (int i = 0; i < 4; i++) begin
      step("t4_pre", ex(0, 0, 0, 16, 5, 0));
    end
    step("t4_b1", ex(1, 1, 1, 32, 0, 0));
    dbg(1, 1, 1, 36, 32'hA2);
    step("t4_b2", ex(1, 1, 1, 36, 0, 0));
    dbg(1, 1, 1, 40, 32'hA3);
    step("t4_b3", ex(1, 1, 1, 40, 0, 0));
    dbg(1, 1, 0, 44, 32'hA4);
    step("t4_b4", ex(1, 1, 1, 44, 0, 0));
    dbg(0, 0, 0, 0, 0);
    cpu(1, 0, 32, 0);
    step("t4_cpu", ex(0, 0, 0, 32, 32'hA1, 0));
    check("t4_mem36", mem[9], 32'hA2);
    check("t4_mem44", mem[11], 32'hA4);

    // reset pulled low mid-lock
    cpu(0, 0, 0, 0);
    dbg(1, 1, 1, 48, 32'hB1);
    step("t5_l1", ex(0, 1, 1, 48, 0, 0));
    cpu(1, 0, 48, 0);
    dbg(1, 1, 1, 52, 32'hB2);
    step("t5_l2", ex(1, 1, 1, 52, 0, 0));
    reset = 1'b0;
    step("t5_rst", ex(0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    step("t5_rel", ex(0, 0, 0, 48, 32'hB1, 0));
    check("t5_mem52", mem[13], 32'hB2);
    check("t5_wr52", wr_cnt[13], 1);

    // debug write denied while CPU loads
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);
    step("t6_idle", ex(0, 0, 0, 0, 0, 0));
    cpu(1, 0, 60, 0);
    dbg(1, 1, 0, 60, 32'hC6);
    for (int i = 0; i < 4; i++) begin
      step("t6_den", ex(0, 0, 0, 60, 0, 0));
    end
    check("t6_mem_pre", mem[15], 0);
    check("t6_wr_pre", wr_cnt[15], 0);
    step("t6_gnt", ex(1, 1, 1, 60, 0, 0));
    check("t6_mem_post", mem[15], 32'hC6);
    dbg(0, 0, 0, 0, 0);
    step("t6_ld", ex(0, 0, 0, 60, 32'hC6, 0));
    check("t6_wr_once", wr_cnt[15], 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
